alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between up to NUM_REQ execute units (store, load, branch, integer) that each drive their own operand, op and valid request.
- Grants one requester per cycle with zero-latency muxing, so the owner sees the ALU result in the same cycle.
- Holds the grant while the owner keeps its request asserted, which supports multi-cycle execute sequences.
- Rotates priority round-robin on release; sits between the execute units and the ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDLE_OP, 5'd8, ALU op driven when no grant is active.
- IDX_W, $clog2(NUM_REQ), owner index width (derived, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester ALU request; bit i belongs to requester i.
- req_in_a  input  33*NUM_REQ  operand A; slice [33*i +: 33] belongs to requester i.
- req_in_b  input  33*NUM_REQ  operand B; slice [33*i +: 33] belongs to requester i.
- req_alu_op  input  5*NUM_REQ  ALU op; slice [5*i +: 5] belongs to requester i.
- grant  output  NUM_REQ  one-hot grant, combinational.
- alu_in_a  output  33  operand A to the ALU.
- alu_in_b  output  33  operand B to the ALU.
- alu_op  output  5  op to the ALU.
- alu_result  input  32  ALU output.
- req_result  output  32  alu_result broadcast to all requesters; valid only where grant is set.
- busy  output  1  registered; an owner is locked.
- owner  output  IDX_W  registered index of the locked owner.
- conflict_count  output  16  registered count of cycles with at least one requester waiting while not granted.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy=0, owner=0, rr_ptr=0, conflict_count=0.
  - grant forced to all zeros while reset is low.
  - alu_in_a=0, alu_in_b=0, alu_op=IDLE_OP.
- States:
  - IDLE (busy=0): grant = first set bit of req_valid searching from rr_ptr upward with wrap-around; no grant if req_valid=0.
  - LOCKED (busy=1): if req_valid[owner]=1, grant=onehot(owner) regardless of other requests.
- Release: in LOCKED with req_valid[owner]=0, the same cycle arbitrates the remaining requesters. The search starts at owner+1 (mod NUM_REQ), so there is no bubble.
- Register update on each rising clk, where g = the granted index this cycle:
  - grant nonzero: busy<=1, owner<=g, rr_ptr<=(g+1) mod NUM_REQ.
  - grant zero: busy<=0; owner and rr_ptr hold.
- Mux:
  - With a grant: alu_in_a, alu_in_b and alu_op are the granted requester's slices.
  - With no grant: operands are 0 and alu_op=IDLE_OP.
  - req_result = alu_result unconditionally.
- A requester that drops and re-raises req_valid in consecutive cycles is a new request and loses to waiting requesters under round-robin.
- conflict_count: increments when (req_valid & ~grant) != 0 and saturates at 16'hFFFF.
- grant is one-hot or zero in every cycle, including reset exit.
- Reset asserted mid-lock: grant drops immediately and the lock is lost. After release, IDLE arbitration restarts from index 0.

Test Plan:
- Single requester: req_valid=4'b0100, in_a=5, in_b=3, op=add. Required: grant=4'b0100 in the same cycle, alu_in_a=5, req_result=8 from the ALU, busy=1 and owner=2 after the edge.
- Lock hold: req 0 held for 3 cycles while req 1 is asserted throughout. Required: grant=4'b0001 for 3 cycles, then 4'b0010 in the cycle req 0 drops, with no idle cycle; conflict_count=3.
- Round-robin fairness: all four requesters pulse for one cycle each and re-request continuously. Required: grant order 0,1,2,3,0 with rr_ptr wrapping 3->0.
- Idle: req_valid=0. Required: grant=0, alu_op=8, alu_in_a=alu_in_b=0, busy=0 after the edge.
- Reset mid-lock: owner=3, busy=1, reset pulsed low asynchronously between edges. Required: grant=0 immediately; after release with req_valid=4'b1001, grant=4'b0001.
- Saturation: force waiting contention for 65540 cycles. Required: conflict_count sticks at 16'hFFFF.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between NUM_REQ execute units. One requester
//   is granted per cycle and its operands/op are muxed straight to the ALU, so
//   the owner sees the result in the same cycle. A granted requester keeps the
//   ALU for as long as it holds req_valid; on release the remaining requesters
//   are arbitrated round-robin in that same cycle (no bubble).
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   req_valid      per-requester request, bit i = requester i
//   req_in_a/b     per-requester 33-bit operands, slice [33*i +: 33]
//   req_alu_op     per-requester 5-bit op, slice [5*i +: 5]
//   grant          one-hot grant (combinational, zero during reset)
//   alu_in_a/b     operands to the ALU (zero when nothing is granted)
//   alu_op         op to the ALU (IDLE_OP when nothing is granted)
//   alu_result     ALU output
//   req_result     alu_result broadcast; meaningful where grant is set
//   busy           registered, an owner is locked
//   owner          registered index of the locked owner
//   conflict_count registered, saturating count of cycles with a waiting requester
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no owner; grant goes to first requester at or after rr_ptr
// ST_LOCKED | owner holds the ALU while its request stays high; on release
//           | the others are arbitrated in the same cycle from owner+1

module alu_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter logic [4:0] IDLE_OP = 5'd8,
    localparam int        IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [33*NUM_REQ-1:0]  req_in_a,
    input  logic [33*NUM_REQ-1:0]  req_in_b,
    input  logic [5*NUM_REQ-1:0]   req_alu_op,
    output logic [NUM_REQ-1:0]     grant,
    output logic [32:0]            alu_in_a,
    output logic [32:0]            alu_in_b,
    output logic [4:0]             alu_op,
    input  logic [31:0]            alu_result,
    output logic [31:0]            req_result,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner,
    output logic [15:0]            conflict_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        conflict_q, conflict_d;

    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
        end
    end

    // Grant selection. Every grant loads rr_ptr with owner+1, so while locked
    // rr_ptr already points one past the owner and the release search can
    // start from rr_ptr in both states.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        grant   = '0;
        if (reset) begin
            if (state_q == ST_LOCKED && req_valid[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                    if (!gnt_any && req_valid[cand]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        conflict_d = conflict_q;
        if (gnt_any) begin
            state_d  = ST_LOCKED;
            owner_d  = gnt_idx;
            rr_ptr_d = IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end else begin
            state_d  = ST_IDLE;
        end
        if (|(req_valid & ~grant) && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_comb begin
        alu_in_a = '0;
        alu_in_b = '0;
        alu_op   = IDLE_OP;
        if (gnt_any) begin
            alu_in_a = req_in_a[33*int'(gnt_idx) +: 33];
            alu_in_b = req_in_b[33*int'(gnt_idx) +: 33];
            alu_op   = req_alu_op[5*int'(gnt_idx) +: 5];
        end
    end

    assign req_result     = alu_result;
    assign busy           = (state_q == ST_LOCKED);
    assign owner          = owner_q;
    assign conflict_count = conflict_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NUM_REQ=4. A small ALU (op 0 = add,
// otherwise xor) is modelled here and fed back into alu_result.

module tb_alu_arbiter;

    logic          clk;
    logic          reset;
    logic [3:0]    req_valid;
    logic [131:0]  req_in_a;
    logic [131:0]  req_in_b;
    logic [19:0]   req_alu_op;
    logic [3:0]    grant;
    logic [32:0]   alu_in_a;
    logic [32:0]   alu_in_b;
    logic [4:0]    alu_op;
    logic [31:0]   alu_result;
    logic [31:0]   req_result;
    logic          busy;
    logic [1:0]    owner;
    logic [15:0]   conflict_count;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NUM_REQ(4), .IDLE_OP(5'd8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_in_a       (req_in_a),
        .req_in_b       (req_in_b),
        .req_alu_op     (req_alu_op),
        .grant          (grant),
        .alu_in_a       (alu_in_a),
        .alu_in_b       (alu_in_b),
        .alu_op         (alu_op),
        .alu_result     (alu_result),
        .req_result     (req_result),
        .busy           (busy),
        .owner          (owner),
        .conflict_count (conflict_count)
    );

    assign alu_result = (alu_op == 5'd0) ? (alu_in_a[31:0] + alu_in_b[31:0])
                                         : (alu_in_a[31:0] ^ alu_in_b[31:0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // grant must be one-hot or zero in every cycle
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(grant)) begin
            errors++;
            $display("FAIL grant_onehot0: got %b want one-hot or zero", grant);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [32:0] a, input logic [32:0] b,
                           input logic [4:0] op);
        req_in_a[33*i +: 33] = a;
        req_in_b[33*i +: 33] = b;
        req_alu_op[5*i +: 5] = op;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 33'(100 + i), 33'(200 + i), 5'(i + 1));
        #3;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
        checks++; if (alu_op !== 5'd8) begin errors++; $display("FAIL rst_alu_op: got %0d want 8", alu_op); end
        checks++; if (alu_in_a !== 33'd0 || alu_in_b !== 33'd0) begin errors++; $display("FAIL rst_operands: got %0d/%0d want 0/0", alu_in_a, alu_in_b); end
        tick();
        checks++; if (busy !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL rst_regs: got busy=%b owner=%0d want 0/0", busy, owner); end
        checks++; if (conflict_count !== 16'd0) begin errors++; $display("FAIL rst_conflict: got %0d want 0", conflict_count); end
        req_valid = 4'b0000;
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(2, 33'd5, 33'd3, 5'd0);
        req_valid = 4'b0100;
        #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
        checks++; if (alu_in_a !== 33'd5 || alu_in_b !== 33'd3) begin errors++; $display("FAIL single_operands: got %0d/%0d want 5/3", alu_in_a, alu_in_b); end
        checks++; if (alu_op !== 5'd0) begin errors++; $display("FAIL single_op: got %0d want 0", alu_op); end
        checks++; if (req_result !== 32'd8) begin errors++; $display("FAIL single_result: got %0d want 8", req_result); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL single_regs: got busy=%b owner=%0d want 1/2", busy, owner); end
        checks++; if (conflict_count !== 16'd0) begin errors++; $display("FAIL single_conflict: got %0d want 0", conflict_count); end
    endtask

    task automatic test_idle();
        req_valid = 4'b0000;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant: got %b want 0000", grant); end
        checks++; if (alu_op !== 5'd8) begin errors++; $display("FAIL idle_op: got %0d want 8", alu_op); end
        checks++; if (alu_in_a !== 33'd0 || alu_in_b !== 33'd0) begin errors++; $display("FAIL idle_operands: got %0d/%0d want 0/0", alu_in_a, alu_in_b); end
        tick();
        checks++; if (busy !== 1'b0 || owner !== 2'd2) begin errors++; $display("FAIL idle_regs: got busy=%b owner=%0d want 0/2", busy, owner); end
    endtask

    task automatic test_lock_hold();
        // rr_ptr is 3 here; search 3 -> 0 picks requester 0
        req_valid = 4'b0011;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lock_hold_c%0d: got %b want 0001", c, grant); end
            tick();
        end
        checks++; if (busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL lock_regs: got busy=%b owner=%0d want 1/0", busy, owner); end
        req_valid = 4'b0010;
        #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL lock_release: got %b want 0010", grant); end
        checks++; if (alu_in_a !== 33'd101) begin errors++; $display("FAIL lock_release_a: got %0d want 101", alu_in_a); end
        checks++; if (conflict_count !== 16'd3) begin errors++; $display("FAIL lock_conflict: got %0d want 3", conflict_count); end
        tick();
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL lock_new_owner: got %0d want 1", owner); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] rv  [5] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // park the pointer at 0 by granting requester 3 first
        req_valid = 4'b1000;
        #1;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rr_prime: got %b want 1000", grant); end
        tick();
        for (int k = 0; k < 5; k++) begin
            req_valid = rv[k];
            #1;
            checks++; if (grant !== exp[k]) begin errors++; $display("FAIL rr_step%0d: got %b want %b", k, grant, exp[k]); end
            tick();
        end
        checks++; if (owner !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL rr_regs: got busy=%b owner=%0d want 1/0", busy, owner); end
        checks++; if (conflict_count !== 16'd8) begin errors++; $display("FAIL rr_conflict: got %0d want 8", conflict_count); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_lock();
        // rr_ptr is 1; search 1,2,3 picks requester 3
        req_valid = 4'b1000;
        #1;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rml_grant: got %b want 1000", grant); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 2'd3) begin errors++; $display("FAIL rml_locked: got busy=%b owner=%0d want 1/3", busy, owner); end
        #2 reset = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rml_grant_drop: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL rml_regs: got busy=%b owner=%0d want 0/0", busy, owner); end
        req_valid = 4'b1001;
        #1 reset = 1'b1;
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rml_restart: got %b want 0001", grant); end
        tick();
        checks++; if (owner !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL rml_after: got busy=%b owner=%0d want 1/0", busy, owner); end
    endtask

    task automatic test_saturation();
        req_valid = 4'b0000;
        reset = 1'b0;
        #1 reset = 1'b1;
        req_valid = 4'b0011;
        repeat (100) tick();
        checks++; if (conflict_count !== 16'd100) begin errors++; $display("FAIL sat_count100: got %0d want 100", conflict_count); end
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sat_grant: got %b want 0001", grant); end
        repeat (65440) tick();
        checks++; if (conflict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h want ffff", conflict_count); end
        tick();
        checks++; if (conflict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_stick: got %h want ffff", conflict_count); end
        req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        req_valid  = '0;
        req_in_a   = '0;
        req_in_b   = '0;
        req_alu_op = '0;
        test_reset();
        test_single();
        test_idle();
        test_lock_hold();
        test_round_robin();
        test_reset_mid_lock();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
